// File: rtl/dot_matrix_pkg.sv
// Shared definitions for the 5x3 dot-matrix glyph path: frame geometry,
// the font ROM used by both encoder and decoder, and the decoder state encoding.
package dot_matrix_pkg;

  localparam int ROWS    = 5;
  localparam int COLS    = 3;
  localparam int FRAME_W = ROWS * COLS;

  // Frame layout is {A,B,C,D,E}; row A occupies bits 14:12, left pixel is the MSB of each row.
  localparam logic [0:15][FRAME_W-1:0] GLYPH_ROM = {
    15'b111_101_101_101_111,  // 0
    15'b010_110_010_010_111,  // 1
    15'b111_001_111_100_111,  // 2
    15'b111_001_111_001_111,  // 3
    15'b101_101_111_001_001,  // 4
    15'b111_100_111_001_111,  // 5
    15'b111_100_111_101_111,  // 6
    15'b111_001_001_001_001,  // 7
    15'b111_101_111_101_111,  // 8
    15'b111_101_111_001_111,  // 9
    15'b111_101_111_101_101,  // A
    15'b100_100_111_101_111,  // b
    15'b111_100_100_100_111,  // C
    15'b001_001_111_101_111,  // d
    15'b111_100_111_100_111,  // E
    15'b111_100_111_100_100   // F
  };

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_MATCH   = 2'd1,
    ST_OUT     = 2'd2
  } state_e;

endpackage

// File: rtl/glyph_match.sv
// Combinational glyph lookup: compares a 15-bit frame against every font entry
// in parallel and encodes the hit; no hit yields match=0, code=0.
module glyph_match
  import dot_matrix_pkg::*;
(
  input  logic [FRAME_W-1:0] i_frame,
  output logic               o_match,
  output logic [3:0]         o_code
);

  logic [15:0] w_hit;

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      w_hit[i] = (i_frame == GLYPH_ROM[i]);
    end
  end

  // Font entries are distinct, so priority order only matters for robustness.
  always_comb begin
    o_match = 1'b0;
    o_code  = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (w_hit[i]) begin
        o_match = 1'b1;
        o_code  = 4'(i);
      end
    end
  end

endmodule

// File: rtl/dot_matrix_decoder.sv
// Receive side of the 5x3 dot-matrix interface: collects one row per beat,
// rebuilds the frame, and returns the recovered hex code over valid/ready.
module dot_matrix_decoder
  import dot_matrix_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             row_valid,
  output logic             row_ready,
  input  logic             row_first,
  input  logic [2:0]       row_data,
  output logic             code_valid,
  input  logic             code_ready,
  output logic [3:0]       code,
  output logic             match,
  output logic [CNT_W-1:0] resync_cnt,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // the source holds its payload stable while valid=1 and ready=0.

  state_e             r_state;
  logic [2:0]         r_idx;
  logic [FRAME_W-1:0] r_frame;
  logic               r_row_ready;
  logic               r_code_valid;
  logic [3:0]         r_code;
  logic               r_match;
  logic [CNT_W-1:0]   r_resync;

  logic               w_accept;
  logic               w_resync_max;
  logic               w_match;
  logic [3:0]         w_code;

  assign w_accept     = row_valid & r_row_ready;
  assign w_resync_max = &r_resync;

  glyph_match u_glyph_match (
    .i_frame (r_frame),
    .o_match (w_match),
    .o_code  (w_code)
  );

  // Rows shift in from the bottom so that after row E the top row sits in bits 14:12.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_COLLECT;
      r_idx        <= 3'd0;
      r_frame      <= '0;
      r_row_ready  <= 1'b1;
      r_code_valid <= 1'b0;
      r_code       <= 4'd0;
      r_match      <= 1'b0;
      r_resync     <= '0;
    end else begin
      case (r_state)
        ST_COLLECT: begin
          if (w_accept) begin
            if (row_first) begin
              r_frame <= {{(FRAME_W-COLS){1'b0}}, row_data};
              r_idx   <= 3'd1;
              if (r_idx != 3'd0 && !w_resync_max) r_resync <= r_resync + CNT_W'(1);
            end else if (r_idx == 3'd0) begin
              if (!w_resync_max) r_resync <= r_resync + CNT_W'(1);
            end else begin
              r_frame <= {r_frame[FRAME_W-COLS-1:0], row_data};
              if (r_idx == 3'd4) begin
                r_idx       <= 3'd0;
                r_state     <= ST_MATCH;
                r_row_ready <= 1'b0;
              end else begin
                r_idx <= r_idx + 3'd1;
              end
            end
          end
        end
        ST_MATCH: begin
          r_code       <= w_code;
          r_match      <= w_match;
          r_code_valid <= 1'b1;
          r_state      <= ST_OUT;
        end
        ST_OUT: begin
          if (code_ready) begin
            r_code_valid <= 1'b0;
            r_row_ready  <= 1'b1;
            r_state      <= ST_COLLECT;
          end
        end
        default: begin
          r_state     <= ST_COLLECT;
          r_row_ready <= 1'b1;
        end
      endcase
    end
  end

  assign row_ready  = r_row_ready;
  assign code_valid = r_code_valid;
  assign code       = r_code;
  assign match      = r_match;
  assign resync_cnt = r_resync;
  assign dbg_state  = r_state;

endmodule

// File: doc/dot_matrix_decoder.md
Name: dot_matrix_decoder

Overview:
- Receive side of the 5x3 dot-matrix glyph interface. The display encoder turns a 4-bit hex code into five 3-bit row patterns; this block takes those patterns in one row per beat, rebuilds the frame and recovers the 4-bit code.
- Used for loop-back self-check of the display path and for reading glyph frames from a bus. Valid/ready on input and output; sequencing is done by a small FSM.

Parameters:
- CNT_W, 8, width of the saturating resync-error counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- row_valid  in  1  input beat valid.
- row_ready  out  1  block can accept a beat.
- row_first  in  1  this beat is row A, the top row of a frame.
- row_data  in  3  pixel row; bit2 is the left pixel, bit0 the right pixel.
- code_valid  out  1  decoded result available.
- code_ready  in  1  downstream accepts the result.
- code  out  4  decoded hex value; 0 when match=0.
- match  out  1  frame equals one of the 16 glyphs.
- resync_cnt  out  CNT_W  saturating count of framing errors.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=COLLECT, row index=0, frame register cleared.
  - row_ready=1, code_valid=0, code=0, match=0, resync_cnt=0.
  - Reset wins over all other activity, mid-frame or mid-output; any partial frame is discarded.
- Accept rule: a beat is accepted on an edge where row_valid=1 and row_ready=1. row_ready=1 only in COLLECT.
- COLLECT:
  - Accepted beat with row_first=1: stored as row A, index=1. If the index was not 0, increment resync_cnt (the partial frame is dropped).
  - Accepted beat with row_first=0 and index=0: discarded, resync_cnt++.
  - Accepted beat with row_first=0 and index 1..4: stored at that index, index++.
  - The beat stored at index 4 (row E) moves the FSM to MATCH and resets the index to 0.
- MATCH (exactly one cycle):
  - Compare the 15-bit frame {A,B,C,D,E} against the glyph ROM.
  - Register code and match, set code_valid=1, go to OUT.
  - Latency: row E accepted at edge k gives code_valid=1 after edge k+1.
- OUT:
  - code, match and code_valid are held stable until code_valid && code_ready at an edge. That edge returns the FSM to COLLECT and clears code_valid.
  - row_ready=0 throughout MATCH and OUT, so row_valid input is ignored.
  - row_ready rises one cycle after the output handshake. No beat is accepted on the same edge as the output handshake.
- Glyph ROM (rows A..E, binary):
  - 0=111,101,101,101,111
  - 1=010,110,010,010,111
  - 2=111,001,111,100,111
  - 3=111,001,111,001,111
  - 4=101,101,111,001,001
  - 5=111,100,111,001,111
  - 6=111,100,111,101,111
  - 7=111,001,001,001,001
  - 8=111,101,111,101,111
  - 9=111,101,111,001,111
  - A=111,101,111,101,101
  - b=100,100,111,101,111
  - C=111,100,100,100,111
  - d=001,001,111,101,111
  - E=111,100,111,100,111
  - F=111,100,111,100,100
  - All 16 entries are distinct, so at most one can hit.
- No hit: match=0, code=0, code_valid still asserts. Every complete frame produces exactly one result.
- resync_cnt saturates at 2^CNT_W-1 and never wraps.

Decomposition:
- Package dot_matrix_pkg holds:
  - localparams ROWS=5, COLS=3.
  - The 16x15-bit GLYPH_ROM constant, shared with the display encoder so both ends use one font.
  - State encoding COLLECT/MATCH/OUT.
- One sub-module: glyph_match. It is combinational: 15-bit frame in, {match, code[3:0]} out, built as a parallel compare plus priority encode. Unit-tested on its own.

Test Plan:
- Frame for 8 (111,101,111,101,111), row_first on row A, code_ready=1 -> code_valid after 2 edges, code=8, match=1, resync_cnt=0.
- All 16 glyphs back-to-back with code_ready=1 -> codes 0..F in order. row_ready low for exactly 2 cycles after each row E.
- Frame 000,000,000,000,000 -> match=0, code=0, code_valid=1.
- Beats at rows A,B,C, then row_first=1 with glyph 1 -> resync_cnt=1, code=1.
- Two row_first=0 beats before a frame -> both discarded, resync_cnt=2, and the next frame decodes correctly.
- Hold code_ready=0 for 10 cycles after a decoded 3:
  - code and code_valid stay stable and row_ready=0; row_valid pulses are ignored.
  - code_ready=1 -> code_valid falls and row_ready rises on the next cycle.
  - Then assert rst_n=0 mid-frame -> all outputs return to their reset values.
